wreg_dest_pipe: RTL and testbench

// - Parametrised successor of the write-register destination mux: selects the register-file

---
 rtl/wreg_dest_pipe_if.sv | 47 ++++
 rtl/wreg_dest_pipe.sv | 109 ++++++++++
 tb/tb_wreg_dest_pipe.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wreg_dest_pipe_if.sv
// ---------------------------------------------------------------------------
// wreg_dest_pipe_if
// Bundles the control/datapath signals of the write-register destination
// pipeline so the CPU datapath can connect to it through one port.
//
// Signals (master = control unit side, slave = wreg_dest_pipe):
//   sel       [1:0]     destination select: 00 rt, 01 SP_REG, 10 LINK_REG, 11 rd
//   rt_in     [ADDR_W]  instruction rt field
//   rd_in     [ADDR_W]  instruction rd field
//   wr_en_in            instruction entering stage 0 writes the register bank
//   advance             shift pipeline this cycle (0 = stall)
//   flush               invalidate all in-flight stages
//   rs_q/rt_q [ADDR_W]  source registers queried for RAW hazards
//   dest_sel  [ADDR_W]  combinational selected destination
//   wb_dest   [ADDR_W]  registered writeback destination (last stage)
//   wb_valid            last stage holds a valid register write
//   hazard_rs/hazard_rt RAW hazard flags for rs_q/rt_q
//   stall_cnt [15:0]    stall-cycle counter (0 when the counter is not built)
// ---------------------------------------------------------------------------
interface wreg_dest_pipe_if #(
    parameter int ADDR_W = 5
);
    logic [1:0]        sel;
    logic [ADDR_W-1:0] rt_in;
    logic [ADDR_W-1:0] rd_in;
    logic              wr_en_in;
    logic              advance;
    logic              flush;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic [ADDR_W-1:0] dest_sel;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_valid;
    logic              hazard_rs;
    logic              hazard_rt;
    logic [15:0]       stall_cnt;

    modport master (
        output sel, rt_in, rd_in, wr_en_in, advance, flush, rs_q, rt_q,
        input  dest_sel, wb_dest, wb_valid, hazard_rs, hazard_rt, stall_cnt
    );

    modport slave (
        input  sel, rt_in, rd_in, wr_en_in, advance, flush, rs_q, rt_q,
        output dest_sel, wb_dest, wb_valid, hazard_rs, hazard_rt, stall_cnt
    );
endinterface

// File: rtl/wreg_dest_pipe.sv
// ---------------------------------------------------------------------------
// wreg_dest_pipe
// Selects the register-file write address (rt / $sp / $ra / rd) and carries
// it through DEPTH in-flight stages. The last stage is the writeback
// destination; every valid stage is compared against the next instruction's
// source registers to raise RAW hazard flags.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears every stage and the stall counter
//   bus    wreg_dest_pipe_if.slave (see interface file for signal list)
//
// Parameters:
//   ADDR_W    register address width
//   DEPTH     number of in-flight stages (>=1); stage DEPTH-1 drives writeback
//   SP_REG    address produced for sel=01
//   LINK_REG  address produced for sel=10
//
// Build option:
//   WREG_STALL_CNT_EN  when defined, stall_cnt counts edges with advance=0
//                      (saturating at 16'hFFFF, cleared only by reset);
//                      when undefined, stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module wreg_dest_pipe #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int SP_REG   = 29,
    parameter int LINK_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    wreg_dest_pipe_if.slave  bus
);

    localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_REG);
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [ADDR_W-1:0] dest_mux;
    logic [DEPTH-1:0]  valid_reg;
    logic [ADDR_W-1:0] dest_reg [DEPTH];
    logic [DEPTH-1:0]  rs_hit;
    logic [DEPTH-1:0]  rt_hit;

    // Destination mux, visible in the same cycle.
    always_comb begin
        dest_mux = bus.rt_in;
        case (bus.sel)
            2'b00:   dest_mux = bus.rt_in;
            2'b01:   dest_mux = SP_ADDR;
            2'b10:   dest_mux = LINK_ADDR;
            default: dest_mux = bus.rd_in;
        endcase
    end

    assign bus.dest_sel = dest_mux;

    // Stage pipeline. Flush only drops valid bits (dest fields keep their
    // value) and wins over advance, so nothing is loaded in a flush cycle.
    // Writes to register 0 are captured but never marked valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_reg[i] <= '0;
            end
        end else if (bus.flush) begin
            valid_reg <= '0;
        end else if (bus.advance) begin
            valid_reg[0] <= bus.wr_en_in && (dest_mux != '0);
            dest_reg[0]  <= dest_mux;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                dest_reg[i]  <= dest_reg[i-1];
            end
        end
    end

    assign bus.wb_dest  = dest_reg[DEPTH-1];
    assign bus.wb_valid = valid_reg[DEPTH-1];

    // Per-stage hazard compare. The instruction currently at the mux input
    // is not yet in flight, so only captured stages participate. A query of
    // register 0 never flags because register 0 is never valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
        assign rs_hit[gi] = valid_reg[gi] && (dest_reg[gi] == bus.rs_q);
        assign rt_hit[gi] = valid_reg[gi] && (dest_reg[gi] == bus.rt_q);
    end

    assign bus.hazard_rs = |rs_hit;
    assign bus.hazard_rt = |rt_hit;

`ifdef WREG_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Counts stalled edges; flush does not clear it, only reset does.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (!bus.advance && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wreg_dest_pipe.sv
// ---------------------------------------------------------------------------
// tb_wreg_dest_pipe
// Directed bench for wreg_dest_pipe (ADDR_W=5, DEPTH=3, SP=29, LINK=31).
// A vector table drives one clock per record and checks dest_sel before the
// edge and wb_dest/wb_valid/hazards after it; hand-written sequences cover
// stall, flush-vs-advance and (with WREG_STALL_CNT_EN) counter saturation.
// ---------------------------------------------------------------------------
module tb_wreg_dest_pipe;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    wreg_dest_pipe_if #(.ADDR_W(5)) bus ();

    wreg_dest_pipe #(
        .ADDR_W   (5),
        .DEPTH    (3),
        .SP_REG   (29),
        .LINK_REG (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       adv;
        logic       fl;
        logic       wr;
        logic [1:0] sel;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] rsq;
        logic [4:0] rtq;
        logic [4:0] e_sel;
        logic [4:0] e_wb;
        logic       e_v;
        logic       e_hrs;
        logic       e_hrt;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input int rst, input int adv, input int fl, input int wr,
                                input int sel, input int rt, input int rd,
                                input int rsq, input int rtq, input int e_sel,
                                input int e_wb, input int e_v, input int e_hrs,
                                input int e_hrt);
        vec_t v;
        v.rst   = 1'(rst);
        v.adv   = 1'(adv);
        v.fl    = 1'(fl);
        v.wr    = 1'(wr);
        v.sel   = 2'(sel);
        v.rt    = 5'(rt);
        v.rd    = 5'(rd);
        v.rsq   = 5'(rsq);
        v.rtq   = 5'(rtq);
        v.e_sel = 5'(e_sel);
        v.e_wb  = 5'(e_wb);
        v.e_v   = 1'(e_v);
        v.e_hrs = 1'(e_hrs);
        v.e_hrt = 1'(e_hrt);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic adv, input logic fl, input logic wr,
                         input logic [1:0] sel, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] rsq, input logic [4:0] rtq);
        reset        = rst;
        bus.advance  = adv;
        bus.flush    = fl;
        bus.wr_en_in = wr;
        bus.sel      = sel;
        bus.rt_in    = rt;
        bus.rd_in    = rd;
        bus.rs_q     = rsq;
        bus.rt_q     = rtq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int wb, input int v, input int hrs,
                           input int hrt);
        chk({tag, ".wb_dest"},   int'(bus.wb_dest),   wb);
        chk({tag, ".wb_valid"},  int'(bus.wb_valid),  v);
        chk({tag, ".hazard_rs"}, int'(bus.hazard_rs), hrs);
        chk({tag, ".hazard_rt"}, int'(bus.hazard_rt), hrt);
    endtask

    int exp_stall;

    initial begin
        total = 0;
        bad   = 0;
        drive(1, 1, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);

        //              rst adv fl wr sel rt rd rsq rtq | sel  wb  v hrs hrt
        vecs[0]  = mk(1, 1, 0, 1, 0, 8, 0,  0,  0,    8,  0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 1, 0, 8, 0,  0,  0,    8,  0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 1, 0, 8, 0,  8,  0,    8,  0, 0, 1, 0);
        vecs[3]  = mk(0, 1, 0, 1, 1, 8, 0,  8, 29,   29,  0, 0, 1, 1);
        vecs[4]  = mk(0, 1, 0, 1, 2, 8, 0, 31,  8,   31,  8, 1, 1, 1);
        vecs[5]  = mk(0, 1, 0, 1, 3, 3, 12, 8, 12,   12, 29, 1, 0, 1);
        vecs[6]  = mk(0, 1, 0, 1, 0, 0, 12, 0, 29,    0, 31, 1, 0, 0);
        vecs[7]  = mk(0, 1, 0, 1, 3, 0, 5,  5,  0,    5, 12, 1, 1, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 9, 5,  5,  9,    9,  0, 0, 1, 0);
        vecs[9]  = mk(0, 1, 0, 1, 1, 9, 5,  5,  9,   29,  5, 1, 1, 0);
        vecs[10] = mk(0, 1, 0, 1, 2, 9, 5,  5, 29,   31,  9, 0, 0, 1);
        vecs[11] = mk(1, 1, 0, 1, 3, 9, 17, 31, 29,  17,  0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].adv, vecs[i].fl, vecs[i].wr, vecs[i].sel,
                  vecs[i].rt, vecs[i].rd, vecs[i].rsq, vecs[i].rtq);
            #1;
            chk($sformatf("vec%0d.dest_sel", i), int'(bus.dest_sel), int'(vecs[i].e_sel));
            tick();
            chk_out($sformatf("vec%0d", i), int'(vecs[i].e_wb), int'(vecs[i].e_v),
                    int'(vecs[i].e_hrs), int'(vecs[i].e_hrt));
            $display("vec %0d: wb_dest=%0d wb_valid=%0d hz_rs=%0d hz_rt=%0d",
                     i, bus.wb_dest, bus.wb_valid, bus.hazard_rs, bus.hazard_rt);
        end
        chk("after_reset.stall_cnt", int'(bus.stall_cnt), 0);

        // Stall: dest 7 into stage1, then hold for 4 cycles.
        drive(0, 1, 0, 1, 2'b00, 5'd7, 5'd0, 5'd20, 5'd7);
        tick();
        drive(0, 1, 0, 0, 2'b00, 5'd1, 5'd0, 5'd20, 5'd7);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 1, 2'b11, 5'd1, 5'd20, 5'd20, 5'd7);
            tick();
            chk_out($sformatf("stall%0d", c), 0, 0, 0, 1);
            $display("stall %0d: hz_rt=%0d stall_cnt=%0d", c, bus.hazard_rt, bus.stall_cnt);
        end
`ifdef WREG_STALL_CNT_EN
        exp_stall = 4;
`else
        exp_stall = 0;
`endif
        chk("stall.stall_cnt", int'(bus.stall_cnt), exp_stall);
        // One more advance must bring 7 to writeback: stages really held.
        drive(0, 1, 0, 0, 2'b00, 5'd2, 5'd0, 5'd20, 5'd7);
        tick();
        chk_out("stall_release", 7, 1, 0, 1);
        $display("stall release: wb_dest=%0d wb_valid=%0d", bus.wb_dest, bus.wb_valid);

        // Flush vs advance: fill three valid stages 10,11,12.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 1, 2'b11, 5'd0, 5'(10 + k), 5'd13, 5'd12);
            tick();
        end
        chk_out("flush_fill", 10, 1, 0, 1);
        drive(0, 1, 1, 1, 2'b11, 5'd0, 5'd13, 5'd13, 5'd12);
        tick();
        chk_out("flush", 10, 0, 0, 0);
        $display("flush: wb_dest=%0d wb_valid=%0d hz_rs=%0d hz_rt=%0d",
                 bus.wb_dest, bus.wb_valid, bus.hazard_rs, bus.hazard_rt);
        drive(0, 1, 0, 0, 2'b00, 5'd3, 5'd0, 5'd13, 5'd12);
        tick();
        chk("flush_post1.wb_dest", int'(bus.wb_dest), 11);
        tick();
        chk("flush_post2.wb_dest", int'(bus.wb_dest), 12);
        chk("flush_post2.wb_valid", int'(bus.wb_valid), 0);
        chk("flush.stall_cnt", int'(bus.stall_cnt), exp_stall);
        $display("flush drain: wb_dest=%0d wb_valid=%0d", bus.wb_dest, bus.wb_valid);

`ifdef WREG_STALL_CNT_EN
        // Saturation: 65540 stalled edges on top of the 4 already counted.
        drive(0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
        repeat (65540) @(posedge clk);
        #1;
        chk("sat.stall_cnt", int'(bus.stall_cnt), 65535);
        $display("saturation: stall_cnt=%0d", bus.stall_cnt);
        drive(1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("sat_reset.stall_cnt", int'(bus.stall_cnt), 0);
        $display("saturation reset: stall_cnt=%0d", bus.stall_cnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
